// File: rtl/lut8_cfg_pkg.sv
// Shared definitions for the reprogrammable LUT8 stage.
//   LUT_BITS      : truth-table size in bits (8 select inputs).
//   cfg_state_e   : load sequencer states.
//   num_words()   : config words per full table load for a given word width.
//   cnt_width()   : width of the word counter, never narrower than 1 bit.
package lut8_cfg_pkg;

  localparam int LUT_BITS = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  function automatic int num_words(input int word_w);
    return LUT_BITS / word_w;
  endfunction

  function automatic int cnt_width(input int word_w);
    int n;
    n = num_words(word_w);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lut8_cfg_loader_if.sv
// Configuration bus of lut8_cfg_loader.
//   CFG_START : begin (or restart) a table load
//   CFG_VALID : CFG_DATA carries a word
//   CFG_DATA  : config word, word k fills table bits [k*WORD_W +: WORD_W]
//   CFG_READY : loader accepts a word this cycle
//   CFG_DONE  : one-cycle pulse, new table active
//   CFG_ERR   : one-cycle pulse, load aborted by restart
//   RB_DATA   : registered readback of the active table word at the counter,
//               present only when LUT8_CFG_READBACK_EN is defined
// master = config source, slave = loader.
interface lut8_cfg_loader_if #(
  parameter int WORD_W = 8
);
  logic              CFG_START;
  logic              CFG_VALID;
  logic [WORD_W-1:0] CFG_DATA;
  logic              CFG_READY;
  logic              CFG_DONE;
  logic              CFG_ERR;
`ifdef LUT8_CFG_READBACK_EN
  logic [WORD_W-1:0] RB_DATA;
`endif

  modport master (
    output CFG_START,
    output CFG_VALID,
    output CFG_DATA,
    input  CFG_READY,
    input  CFG_DONE,
    input  CFG_ERR
`ifdef LUT8_CFG_READBACK_EN
    , input RB_DATA
`endif
  );

  modport slave (
    input  CFG_START,
    input  CFG_VALID,
    input  CFG_DATA,
    output CFG_READY,
    output CFG_DONE,
    output CFG_ERR
`ifdef LUT8_CFG_READBACK_EN
    , output RB_DATA
`endif
  );

endinterface

// File: rtl/lut8_table.sv
// Active truth table and registered lookup of the LUT8 stage.
//   clk, srst : clock, synchronous active-high reset (table -> INIT, z -> 0)
//   commit    : copy shadow into the active table on this edge
//   shadow    : fully loaded table from the loader
//   sel       : lookup index {H,G,F,E,D,C,B,A}
//   en        : lookup enable, z holds when low
//   z         : registered lookup result
//   active    : active table (only with LUT8_CFG_READBACK_EN, for readback)
// The lookup and the commit share one edge; the lookup reads active_reg
// before the update, so the commit edge still returns the old table and a
// half-written table can never be observed.
module lut8_table
  import lut8_cfg_pkg::*;
#(
  parameter logic [LUT_BITS-1:0] INIT = '0
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                commit,
  input  logic [LUT_BITS-1:0] shadow,
  input  logic [7:0]          sel,
  input  logic                en,
`ifdef LUT8_CFG_READBACK_EN
  output logic [LUT_BITS-1:0] active,
`endif
  output logic                z
);

  logic [LUT_BITS-1:0] active_reg;
  logic                z_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      active_reg <= INIT;
      z_reg      <= 1'b0;
    end else begin
      if (commit) begin
        active_reg <= shadow;
      end
      if (en) begin
        z_reg <= active_reg[sel];
      end
    end
  end

`ifdef LUT8_CFG_READBACK_EN
  assign active = active_reg;
`endif
  assign z = z_reg;

endmodule

// File: rtl/lut8_cfg_loader.sv
// Runtime-reprogrammable LUT8: the 256-bit truth table is streamed in as
// WORD_W-bit words into a shadow register and committed atomically.
//   CK        : clock, rising edge
//   LSR       : synchronous active-high reset
//   A..H      : lookup select, A = LSB, H = MSB
//   EN        : lookup enable
//   Z         : registered lookup result (1-cycle latency)
//   cfg       : configuration bus (lut8_cfg_loader_if.slave)
// Parameters: INIT (table after reset), WORD_W (1,2,4,8,16,32).
// Optional macro LUT8_CFG_READBACK_EN adds cfg.RB_DATA, a registered copy of
// the active table word addressed by the word counter.
module lut8_cfg_loader
  import lut8_cfg_pkg::*;
#(
  parameter logic [LUT_BITS-1:0] INIT   = '0,
  parameter int                  WORD_W = 8
) (
  input  logic             CK,
  input  logic             LSR,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             E,
  input  logic             F,
  input  logic             G,
  input  logic             H,
  input  logic             EN,
  output logic             Z,
  lut8_cfg_loader_if.slave cfg
);

  localparam int NUM_WORDS = num_words(WORD_W);
  localparam int CNT_W     = cnt_width(WORD_W);

  if (!(WORD_W == 1 || WORD_W == 2 || WORD_W == 4 ||
        WORD_W == 8 || WORD_W == 16 || WORD_W == 32)) begin : g_bad_word_w
    $error("lut8_cfg_loader: WORD_W must be 1, 2, 4, 8, 16 or 32");
  end

  cfg_state_e          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [LUT_BITS-1:0] shadow_reg;
  logic                done_reg, done_next;
  logic                err_reg, err_next;
  logic                ready;
  logic                word_we;
  logic                commit;
  logic [NUM_WORDS-1:0] word_wr;

  // Sequencer. A restart in LOAD takes priority over a same-cycle word so
  // the word is dropped and counting starts over from word 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    ready      = 1'b0;
    word_we    = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg.CFG_START) begin
          state_next = LOAD;
          cnt_next   = '0;
        end
      end
      LOAD: begin
        ready = 1'b1;
        if (cfg.CFG_START) begin
          cnt_next = '0;
          err_next = 1'b1;
        end else if (cfg.CFG_VALID) begin
          word_we = 1'b1;
          // Counter parks at the last word instead of wrapping.
          if (cnt_reg == CNT_W'(NUM_WORDS - 1)) begin
            state_next = COMMIT;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (LSR) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // One write strobe per shadow word.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word_wr
    assign word_wr[gi] = word_we && (cnt_reg == CNT_W'(gi));
  end

  // Reset reloads INIT so a load interrupted by reset leaves nothing behind.
  always_ff @(posedge CK) begin
    if (LSR) begin
      shadow_reg <= INIT;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (word_wr[i]) begin
          shadow_reg[i*WORD_W +: WORD_W] <= cfg.CFG_DATA;
        end
      end
    end
  end

`ifdef LUT8_CFG_READBACK_EN
  logic [LUT_BITS-1:0] active;
`endif

  lut8_table #(
    .INIT (INIT)
  ) u_table (
    .clk    (CK),
    .srst   (LSR),
    .commit (commit),
    .shadow (shadow_reg),
    .sel    ({H, G, F, E, D, C, B, A}),
    .en     (EN),
`ifdef LUT8_CFG_READBACK_EN
    .active (active),
`endif
    .z      (Z)
  );

`ifdef LUT8_CFG_READBACK_EN
  // Readback follows the counter value being loaded this edge, so after an
  // accepted word it already shows the old table's next word.
  logic [WORD_W-1:0] active_words [NUM_WORDS];
  logic [WORD_W-1:0] rb_data_reg;

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_rb_words
    assign active_words[gi] = active[gi*WORD_W +: WORD_W];
  end

  always_ff @(posedge CK) begin
    if (LSR) begin
      rb_data_reg <= '0;
    end else begin
      rb_data_reg <= active_words[cnt_next];
    end
  end

  assign cfg.RB_DATA = rb_data_reg;
`endif

  assign cfg.CFG_READY = ready;
  assign cfg.CFG_DONE  = done_reg;
  assign cfg.CFG_ERR   = err_reg;

endmodule

// File: tb/tb_lut8_cfg_loader.sv
// Self-checking bench for lut8_cfg_loader (WORD_W = 8). The reference model
// is a plain 256-bit table that the bench swaps to the newly loaded contents
// at the cycle the new table must become visible.
module tb_lut8_cfg_loader;

  localparam int WORD_W = 8;
  localparam int NW     = 256 / WORD_W;
  localparam logic [255:0] INIT_TAB =
    256'hDEADBEEF_0BADF00D_12345658_9ABCDEF0_CAFEF00D_55AA33CC_0F1E2D3C_4B5A0121;

  logic       CK = 1'b0;
  logic       LSR;
  logic [7:0] sel_drv;
  logic       en_drv;
  logic       Z;

  int errors = 0;
  int checks = 0;

  logic [255:0] cur_tab;
  logic         exp_z;
  bit           rand_lu;
  logic [7:0]   wq [NW];
  logic [7:0]   wr [NW];

  always #5 CK = ~CK;

  lut8_cfg_loader_if #(.WORD_W(WORD_W)) cfg_bus ();

  lut8_cfg_loader #(
    .INIT   (INIT_TAB),
    .WORD_W (WORD_W)
  ) dut (
    .CK  (CK),
    .LSR (LSR),
    .A   (sel_drv[0]),
    .B   (sel_drv[1]),
    .C   (sel_drv[2]),
    .D   (sel_drv[3]),
    .E   (sel_drv[4]),
    .F   (sel_drv[5]),
    .G   (sel_drv[6]),
    .H   (sel_drv[7]),
    .EN  (en_drv),
    .Z   (Z),
    .cfg (cfg_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check Z against the model table as it was
  // before that edge.
  task automatic tick();
    @(posedge CK);
    #1;
    if (LSR) exp_z = 1'b0;
    else if (en_drv) exp_z = cur_tab[sel_drv];
    chk("z", {31'b0, Z}, {31'b0, exp_z});
    if (rand_lu) begin
      en_drv  = ($urandom_range(0, 3) != 0);
      sel_drv = 8'($urandom);
    end
  endtask

  // gap_mode: 0 = VALID every cycle, 1 = VALID every other cycle, 2 = random.
  // restart_at / reset_at: word index at which to restart / reset (-1 = never).
  task automatic run_load(input int gap_mode, input int restart_at, input int reset_at);
    int           idx;
    int           cyc;
    bit           restarted;
    bit           exp_err;
    bit           v;
    logic [255:0] new_tab;
    idx = 0; cyc = 0; restarted = 0; exp_err = 0;
    cfg_bus.CFG_START = 1'b1;
    cfg_bus.CFG_VALID = 1'b0;
    tick();
    cfg_bus.CFG_START = 1'b0;
    while (idx < NW) begin
      chk("ready_in_load", {31'b0, cfg_bus.CFG_READY}, 32'd1);
      chk("done_in_load", {31'b0, cfg_bus.CFG_DONE}, 32'd0);
      chk("err_in_load", {31'b0, cfg_bus.CFG_ERR}, {31'b0, exp_err});
`ifdef LUT8_CFG_READBACK_EN
      chk("rb_data", {24'b0, cfg_bus.RB_DATA}, {24'b0, cur_tab[idx*8 +: 8]});
`endif
      exp_err = 0;
      if (!restarted && idx == restart_at) begin
        cfg_bus.CFG_START = 1'b1;
        cfg_bus.CFG_VALID = 1'b1;
        cfg_bus.CFG_DATA  = 8'hC3;
        tick();
        cfg_bus.CFG_START = 1'b0;
        cfg_bus.CFG_VALID = 1'b0;
        restarted = 1;
        idx = 0;
        exp_err = 1;
        continue;
      end
      if (idx == reset_at) begin
        cfg_bus.CFG_VALID = 1'b0;
        LSR = 1'b1;
        tick();
        LSR = 1'b0;
        cur_tab = INIT_TAB;
        chk("ready_after_rst", {31'b0, cfg_bus.CFG_READY}, 32'd0);
        chk("done_after_rst", {31'b0, cfg_bus.CFG_DONE}, 32'd0);
        chk("err_after_rst", {31'b0, cfg_bus.CFG_ERR}, 32'd0);
        // Words offered in IDLE must be ignored and no DONE may follow.
        cfg_bus.CFG_VALID = 1'b1;
        cfg_bus.CFG_DATA  = 8'h5A;
        for (int k = 0; k < 4; k++) begin
          tick();
          chk("ready_idle", {31'b0, cfg_bus.CFG_READY}, 32'd0);
          chk("done_idle", {31'b0, cfg_bus.CFG_DONE}, 32'd0);
        end
        cfg_bus.CFG_VALID = 1'b0;
        $display("load aborted by reset after %0d words", idx);
        return;
      end
      v = (gap_mode == 0) ? 1'b1 :
          (gap_mode == 1) ? (cyc % 2 == 0) :
          (($urandom_range(0, 2) != 0) || (cyc % 4 == 3));
      cfg_bus.CFG_VALID = v;
      cfg_bus.CFG_DATA  = restarted ? wr[idx] : wq[idx];
      tick();
      cyc++;
      if (v) idx++;
    end
    cfg_bus.CFG_VALID = 1'b0;
    for (int k = 0; k < NW; k++) new_tab[k*8 +: 8] = restarted ? wr[k] : wq[k];
    // Commit cycle: loader busy, nothing reported yet.
    chk("ready_commit", {31'b0, cfg_bus.CFG_READY}, 32'd0);
    chk("done_commit", {31'b0, cfg_bus.CFG_DONE}, 32'd0);
    chk("err_commit", {31'b0, cfg_bus.CFG_ERR}, 32'd0);
    tick();
    chk("done_pulse", {31'b0, cfg_bus.CFG_DONE}, 32'd1);
    chk("ready_after_commit", {31'b0, cfg_bus.CFG_READY}, 32'd0);
    chk("err_with_done", {31'b0, cfg_bus.CFG_ERR}, 32'd0);
    cur_tab = new_tab;
    tick();
    chk("done_single", {31'b0, cfg_bus.CFG_DONE}, 32'd0);
    $display("load gap_mode=%0d restart=%0d cycles=%0d committed", gap_mode, restarted, cyc);
  endtask

  initial begin
    LSR = 1'b1;
    en_drv = 1'b0;
    sel_drv = 8'h00;
    rand_lu = 0;
    exp_z = 1'b0;
    cur_tab = INIT_TAB;
    cfg_bus.CFG_START = 1'b0;
    cfg_bus.CFG_VALID = 1'b0;
    cfg_bus.CFG_DATA  = '0;
    tick();
    tick();
    chk("rst_ready", {31'b0, cfg_bus.CFG_READY}, 32'd0);
    chk("rst_done", {31'b0, cfg_bus.CFG_DONE}, 32'd0);
    chk("rst_err", {31'b0, cfg_bus.CFG_ERR}, 32'd0);
    LSR = 1'b0;

    // INIT lookups and EN hold.
    en_drv = 1'b1; sel_drv = 8'h00;
    tick();
    chk("init_sel00", {31'b0, Z}, 32'd1);
    sel_drv = 8'h01;
    tick();
    chk("init_sel01", {31'b0, Z}, 32'd0);
    en_drv = 1'b0; sel_drv = 8'h00;
    tick();
    chk("en_hold", {31'b0, Z}, 32'd0);
    $display("reset and INIT lookup done");

    // VALID in IDLE is ignored.
    cfg_bus.CFG_VALID = 1'b1;
    tick();
    chk("idle_ready", {31'b0, cfg_bus.CFG_READY}, 32'd0);
    cfg_bus.CFG_VALID = 1'b0;

    // Gapless load of all ones, continuously looking up 8'hA5.
    for (int k = 0; k < NW; k++) wq[k] = 8'hFF;
    en_drv = 1'b1; sel_drv = 8'hA5;
    run_load(0, -1, -1);
    chk("a5_new_table", {31'b0, Z}, 32'd1);

    // VALID toggling, random words, top word 8'h80.
    for (int k = 0; k < NW; k++) wq[k] = 8'($urandom);
    wq[NW-1] = 8'h80;
    rand_lu = 1;
    run_load(1, -1, -1);
    rand_lu = 0;
    en_drv = 1'b1; sel_drv = 8'hFF;
    tick();
    chk("top_sel_ff", {31'b0, Z}, 32'd1);
    sel_drv = 8'hFE;
    tick();
    chk("top_sel_fe", {31'b0, Z}, 32'd0);

    // Restart after 10 words, then a full load of zeros.
    for (int k = 0; k < NW; k++) begin
      wq[k] = 8'($urandom) | 8'h01;
      wr[k] = 8'h00;
    end
    rand_lu = 1;
    run_load(2, 10, -1);
    rand_lu = 0;
    en_drv = 1'b1;
    for (int s = 0; s < 256; s++) begin
      sel_drv = 8'(s);
      tick();
    end
    chk("zero_table_z", {31'b0, Z}, 32'd0);

    // Reset after 20 words reverts to INIT.
    for (int k = 0; k < NW; k++) wq[k] = 8'($urandom);
    rand_lu = 1;
    run_load(0, -1, 20);
    rand_lu = 0;
    en_drv = 1'b1;
    for (int s = 0; s < 256; s++) begin
      sel_drv = 8'(s);
      tick();
    end

    // One more random load after the reset.
    for (int k = 0; k < NW; k++) wq[k] = 8'($urandom);
    rand_lu = 1;
    run_load(2, -1, -1);
    for (int k = 0; k < 40; k++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
